// File: rtl/sensor_portao_pkg.sv
// Shared definitions for the gate-sensor front end:
// FSM state encoding and count-direction constants.
package sensor_portao_pkg;

  localparam logic [2:0] ST_OCIOSO = 3'd0;
  localparam logic [2:0] ST_ENT_A  = 3'd1;
  localparam logic [2:0] ST_ENT_AB = 3'd2;
  localparam logic [2:0] ST_ENT_B  = 3'd3;
  localparam logic [2:0] ST_SAI_B  = 3'd4;
  localparam logic [2:0] ST_SAI_BA = 3'd5;
  localparam logic [2:0] ST_SAI_A  = 3'd6;
  localparam logic [2:0] ST_ERRO   = 3'd7;

  typedef enum logic [2:0] {
    OCIOSO = ST_OCIOSO,
    ENT_A  = ST_ENT_A,
    ENT_AB = ST_ENT_AB,
    ENT_B  = ST_ENT_B,
    SAI_B  = ST_SAI_B,
    SAI_BA = ST_SAI_BA,
    SAI_A  = ST_SAI_A,
    ERRO   = ST_ERRO
  } estado_t;

  localparam logic DIR_ENTRA = 1'b0;
  localparam logic DIR_SAI   = 1'b1;

endpackage

// File: rtl/debounce_sinal.sv
// Two-flop synchronizer followed by a counting debouncer;
// the output follows the input after DEBOUNCE_CYCLES stable samples.
module debounce_sinal
  import sensor_portao_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CMAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1;
  logic          s2;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      dout <= 1'b0;
      cnt  <= '0;
    end else begin
      s1 <= din;
      s2 <= s1;
      if (s2 == dout) begin
        cnt <= '0;
      end else if (cnt == CMAX) begin
        dout <= s2;
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/sensor_portao.sv
// Gate passage tracker: debounces both beams and emits one
// count strobe per completed entry or exit.
module sensor_portao
  import sensor_portao_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic sensor_a,
  input  logic sensor_b,
  output logic somar,
  output logic decrem,
  output logic erro,
  output logic ocupado
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT_CYCLES);

  logic          da;
  logic          db;
  estado_t       st;
  estado_t       st_nx;
  logic [TW-1:0] idade;
  logic          somar_nx;
  logic          dir_nx;
  logic          esgotado;

  debounce_sinal #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_a (
    .clk  (clk),
    .reset(reset),
    .din  (sensor_a),
    .dout (da)
  );

  debounce_sinal #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb_b (
    .clk  (clk),
    .reset(reset),
    .din  (sensor_b),
    .dout (db)
  );

  assign esgotado = (idade == TMAX) &&
                    (st != OCIOSO) && (st != ERRO);

  always_comb begin
    st_nx    = st;
    somar_nx = 1'b0;
    dir_nx   = DIR_ENTRA;
    unique case (st)
      OCIOSO:
        unique case ({da, db})
          2'b10:   st_nx = ENT_A;
          2'b01:   st_nx = SAI_B;
          2'b11:   st_nx = ERRO;
          default: st_nx = OCIOSO;
        endcase
      ENT_A:
        unique case ({da, db})
          2'b11:   st_nx = ENT_AB;
          2'b00:   st_nx = OCIOSO;
          2'b01:   st_nx = ERRO;
          default: st_nx = ENT_A;
        endcase
      ENT_AB:
        unique case ({da, db})
          2'b01:   st_nx = ENT_B;
          2'b10:   st_nx = ENT_A;
          2'b00:   st_nx = ERRO;
          default: st_nx = ENT_AB;
        endcase
      ENT_B:
        unique case ({da, db})
          2'b00: begin
            st_nx    = OCIOSO;
            somar_nx = 1'b1;
            dir_nx   = DIR_ENTRA;
          end
          2'b11:   st_nx = ENT_AB;
          2'b10:   st_nx = ERRO;
          default: st_nx = ENT_B;
        endcase
      SAI_B:
        unique case ({da, db})
          2'b11:   st_nx = SAI_BA;
          2'b00:   st_nx = OCIOSO;
          2'b10:   st_nx = ERRO;
          default: st_nx = SAI_B;
        endcase
      SAI_BA:
        unique case ({da, db})
          2'b10:   st_nx = SAI_A;
          2'b01:   st_nx = SAI_B;
          2'b00:   st_nx = ERRO;
          default: st_nx = SAI_BA;
        endcase
      SAI_A:
        unique case ({da, db})
          2'b00: begin
            st_nx    = OCIOSO;
            somar_nx = 1'b1;
            dir_nx   = DIR_SAI;
          end
          2'b11:   st_nx = SAI_BA;
          2'b01:   st_nx = ERRO;
          default: st_nx = SAI_A;
        endcase
      ERRO:
        if (!da && !db) st_nx = OCIOSO;
      default: st_nx = ERRO;
    endcase
    // a stuck passage is abandoned with no count
    if (esgotado) begin
      st_nx    = ERRO;
      somar_nx = 1'b0;
      dir_nx   = DIR_ENTRA;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st      <= OCIOSO;
      idade   <= '0;
      somar   <= 1'b0;
      decrem  <= 1'b0;
      erro    <= 1'b0;
      ocupado <= 1'b0;
    end else begin
      st <= st_nx;
      if (st_nx != st) begin
        idade <= '0;
      end else if (idade != TMAX) begin
        idade <= idade + 1'b1;
      end
      somar   <= somar_nx;
      decrem  <= somar_nx & dir_nx;
      erro    <= (st_nx == ERRO);
      ocupado <= (st_nx != OCIOSO);
    end
  end

endmodule

// File: tb/tb_sensor_portao.sv
// Scenario bench for sensor_portao with a passage-level
// reference model driving randomized beam sequences.
module tb_sensor_portao;

  logic clk = 1'b0;
  logic reset;
  logic sensor_a;
  logic sensor_b;
  logic somar;
  logic decrem;
  logic erro;
  logic ocupado;

  int checks   = 0;
  int failures = 0;

  int n_ent;
  int n_sai;
  int n_adj;
  int n_bad;
  int n_erro;
  bit ocup_seen;
  bit prev_somar;

  sensor_portao #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .sensor_a(sensor_a),
    .sensor_b(sensor_b),
    .somar   (somar),
    .decrem  (decrem),
    .erro    (erro),
    .ocupado (ocupado)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (reset) begin
      prev_somar = 1'b0;
    end else begin
      if (somar) begin
        if (decrem) n_sai++;
        else n_ent++;
        if (prev_somar) n_adj++;
      end
      if (!somar && decrem) n_bad++;
      if (erro) n_erro++;
      if (ocupado) ocup_seen = 1'b1;
      prev_somar = somar;
    end
  end

  task automatic clear_stats();
    n_ent = 0;
    n_sai = 0;
    n_adj = 0;
    n_bad = 0;
    n_erro = 0;
    ocup_seen = 1'b0;
  endtask

  task automatic hold(input logic a, input logic b, input int n);
    sensor_a = a;
    sensor_b = b;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Passage model: a vehicle's position along its own direction of
  // travel (1 = first beam, 2 = both, 3 = second beam) may only move
  // by one step; leaving from 3 counts, leaving from 1 aborts.
  function automatic int pos_of(input bit dir, input int lvl);
    int a = (lvl >> 1) & 1;
    int b = lvl & 1;
    if (lvl == 0) return 0;
    if (lvl == 3) return 2;
    if (dir == 1'b0) return a ? 1 : 3;
    return b ? 1 : 3;
  endfunction

  function automatic void model(input int q[$], output int e,
                                output int s);
    bit err = 0;
    bit dir = 0;
    int pos = 0;
    int np;
    e = 0;
    s = 0;
    foreach (q[i]) begin
      if (err) begin
        if (q[i] == 0) begin
          err = 0;
          pos = 0;
        end
      end else if (pos == 0) begin
        if (q[i] == 3) err = 1;
        else if (q[i] != 0) begin
          dir = (q[i] == 1);
          pos = 1;
        end
      end else begin
        np = pos_of(dir, q[i]);
        if (np == 0) begin
          if (pos == 3) begin
            if (dir) s++;
            else e++;
          end else if (pos == 2) err = 1;
          pos = 0;
        end else if (np - pos == 1 || pos - np == 1) begin
          pos = np;
        end else if (np != pos) begin
          err = 1;
        end
      end
    end
  endfunction

  task automatic test_reset();
    reset = 1'b1;
    sensor_a = 1'b0;
    sensor_b = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (somar !== 1'b0) begin
      failures++;
      $display("FAIL reset_somar got=%b exp=0", somar);
    end
    checks++;
    if (decrem !== 1'b0) begin
      failures++;
      $display("FAIL reset_decrem got=%b exp=0", decrem);
    end
    checks++;
    if (erro !== 1'b0) begin
      failures++;
      $display("FAIL reset_erro got=%b exp=0", erro);
    end
    checks++;
    if (ocupado !== 1'b0) begin
      failures++;
      $display("FAIL reset_ocupado got=%b exp=0", ocupado);
    end
    reset = 1'b0;
    hold(0, 0, 5);
  endtask

  task automatic do_entry();
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    hold(0, 0, 10);
  endtask

  task automatic do_exit();
    hold(0, 1, 10);
    hold(1, 1, 10);
    hold(1, 0, 10);
    hold(0, 0, 10);
  endtask

  task automatic test_entry();
    clear_stats();
    do_entry();
    checks++;
    if (n_ent !== 1 || n_sai !== 0) begin
      failures++;
      $display("FAIL entry_count got ent=%0d sai=%0d exp ent=1 sai=0",
               n_ent, n_sai);
    end
    checks++;
    if (n_erro !== 0 || n_bad !== 0) begin
      failures++;
      $display("FAIL entry_clean got erro=%0d bad=%0d exp 0 0",
               n_erro, n_bad);
    end
  endtask

  task automatic test_back_to_back();
    clear_stats();
    do_exit();
    checks++;
    if (n_sai !== 1 || n_ent !== 0) begin
      failures++;
      $display("FAIL exit_count got ent=%0d sai=%0d exp ent=0 sai=1",
               n_ent, n_sai);
    end
    do_entry();
    do_entry();
    do_entry();
    checks++;
    if (n_ent !== 3 || n_sai !== 1) begin
      failures++;
      $display("FAIL b2b_count got ent=%0d sai=%0d exp ent=3 sai=1",
               n_ent, n_sai);
    end
    checks++;
    if (n_adj !== 0 || n_bad !== 0 || n_erro !== 0) begin
      failures++;
      $display("FAIL b2b_iso got adj=%0d bad=%0d erro=%0d exp 0 0 0",
               n_adj, n_bad, n_erro);
    end
  endtask

  task automatic test_reversal();
    clear_stats();
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(1, 0, 10);
    hold(0, 0, 10);
    checks++;
    if (n_ent + n_sai !== 0 || n_erro !== 0) begin
      failures++;
      $display("FAIL reversal got strobes=%0d erro=%0d exp 0 0",
               n_ent + n_sai, n_erro);
    end
    checks++;
    if (ocupado !== 1'b0) begin
      failures++;
      $display("FAIL reversal_idle got ocupado=%b exp=0", ocupado);
    end
  endtask

  task automatic test_glitch();
    clear_stats();
    hold(1, 0, 3);
    hold(0, 0, 15);
    checks++;
    if (ocup_seen !== 1'b0) begin
      failures++;
      $display("FAIL glitch3 got ocupado_seen=%b exp=0", ocup_seen);
    end
    clear_stats();
    hold(1, 0, 4);
    hold(0, 0, 15);
    checks++;
    if (ocup_seen !== 1'b1 || n_ent + n_sai !== 0) begin
      failures++;
      $display("FAIL glitch4 got seen=%b strobes=%0d exp 1 0",
               ocup_seen, n_ent + n_sai);
    end
  endtask

  task automatic test_timeout();
    clear_stats();
    hold(1, 0, 60);
    checks++;
    if (erro !== 1'b1 || n_ent + n_sai !== 0) begin
      failures++;
      $display("FAIL timeout got erro=%b strobes=%0d exp 1 0",
               erro, n_ent + n_sai);
    end
    hold(0, 0, 10);
    checks++;
    if (erro !== 1'b0 || ocupado !== 1'b0) begin
      failures++;
      $display("FAIL err_clear got erro=%b ocupado=%b exp 0 0",
               erro, ocupado);
    end
    clear_stats();
    do_entry();
    checks++;
    if (n_ent !== 1 || n_sai !== 0) begin
      failures++;
      $display("FAIL post_err got ent=%0d sai=%0d exp ent=1 sai=0",
               n_ent, n_sai);
    end
  endtask

  task automatic test_reset_mid();
    clear_stats();
    hold(1, 0, 10);
    hold(1, 1, 10);
    hold(0, 1, 10);
    checks++;
    if (ocupado !== 1'b1) begin
      failures++;
      $display("FAIL mid_busy got ocupado=%b exp=1", ocupado);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++;
    if ({somar, decrem, erro, ocupado} !== 4'b0000) begin
      failures++;
      $display("FAIL mid_reset got outs=%b exp=0000",
               {somar, decrem, erro, ocupado});
    end
    hold(0, 1, 10);
    hold(0, 0, 15);
    checks++;
    if (n_ent + n_sai !== 0) begin
      failures++;
      $display("FAIL mid_nostrobe got strobes=%0d exp=0",
               n_ent + n_sai);
    end
  endtask

  task automatic test_random();
    int q[$];
    int len;
    int lvl;
    int nxt;
    int e;
    int s;
    for (int t = 0; t < 25; t++) begin
      q.delete();
      len = $urandom_range(3, 9);
      lvl = 0;
      for (int k = 0; k < len; k++) begin
        do nxt = $urandom_range(0, 3); while (nxt == lvl);
        q.push_back(nxt);
        lvl = nxt;
      end
      if (lvl != 0) q.push_back(0);
      model(q, e, s);
      clear_stats();
      foreach (q[i]) hold(q[i][1], q[i][0], 10);
      hold(0, 0, 5);
      checks++;
      if (n_ent !== e || n_sai !== s || n_adj !== 0 || n_bad !== 0) begin
        failures++;
        $display("FAIL rand%0d got ent=%0d sai=%0d adj=%0d bad=%0d exp ent=%0d sai=%0d adj=0 bad=0",
                 t, n_ent, n_sai, n_adj, n_bad, e, s);
      end
      checks++;
      if (erro !== 1'b0 || ocupado !== 1'b0) begin
        failures++;
        $display("FAIL rand%0d_idle got erro=%b ocupado=%b exp 0 0",
                 t, erro, ocupado);
      end
    end
  endtask

  initial begin
    clear_stats();
    prev_somar = 1'b0;
    test_reset();
    test_entry();
    test_back_to_back();
    test_reversal();
    test_glitch();
    test_timeout();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
